// File: rtl/board_ram_writer_pkg.sv
// Shared board definitions: command opcodes, cell encodings, writer FSM states.
// Cell encodings are also used by dynamic_screen for colour lookup.
package board_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_HIT   = 2'b10;
  localparam logic [1:0] CELL_MISS  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VB,
    ST_WR,
    ST_FILL,
    ST_ERR
  } state_e;

endpackage

// File: rtl/board_ram_writer_if.sv
// Command handshake plus board-RAM write port of one board_ram_writer.
// master: game logic side (drives cmd_*), slave: the writer (drives ram_*, done, err).
interface board_ram_writer_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_x;
  logic [3:0]        cmd_y;
  logic [1:0]        cmd_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_wdata;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    input  cmd_ready, ram_we, ram_addr, ram_wdata, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    output cmd_ready, ram_we, ram_addr, ram_wdata, done, err
  );
endinterface

// File: rtl/board_ram_writer.sv
// Turns WRITE/FILL commands into single-cycle board-RAM write strobes.
// Ports: clk, rst (async high), vblank, bus (cmd handshake + RAM write port).
module board_ram_writer
  import board_pkg::*;
#(
  parameter int unsigned GRID_W      = 10,
  parameter int unsigned GRID_H      = 10,
  parameter int unsigned ADDR_W      = 7,
  parameter bit          SYNC_VBLANK = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic vblank,
  board_ram_writer_if.slave bus
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  state_e            state_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        wdata_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        data_q;
  logic [ADDR_W-1:0] cnt_q;

  logic [31:0]       addr_full_d;
  logic [ADDR_W-1:0] addr_d;
  logic              range_bad_d;
  logic              op_bad_d;
  logic              gate_d;
  logic              accept_d;

  always_comb begin
    addr_full_d = 32'(bus.cmd_y) * GRID_W + 32'(bus.cmd_x);
    addr_d      = addr_full_d[ADDR_W-1:0];
    range_bad_d = (32'(bus.cmd_x) >= GRID_W) ||
                  (32'(bus.cmd_y) >= GRID_H);
    op_bad_d    = (bus.cmd_op != OP_WRITE) &&
                  (bus.cmd_op != OP_FILL);
    // Gate is sampled on the edge that enters a write cycle.
    gate_d      = !SYNC_VBLANK || vblank;
    accept_d    = bus.cmd_valid && ready_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            ready_q <= 1'b0;
            data_q  <= bus.cmd_data;
            waddr_q <= addr_d;
            if (op_bad_d ||
                (bus.cmd_op == OP_WRITE && range_bad_d)) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else if (bus.cmd_op == OP_FILL) begin
              state_q <= ST_FILL;
              if (gate_d) begin
                we_q    <= 1'b1;
                addr_q  <= '0;
                wdata_q <= bus.cmd_data;
                done_q  <= (LAST == '0);
                cnt_q   <= ADDR_W'(1);
              end else begin
                cnt_q   <= '0;
              end
            end else if (gate_d) begin
              state_q <= ST_WR;
              we_q    <= 1'b1;
              addr_q  <= addr_d;
              wdata_q <= bus.cmd_data;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_WAIT_VB;
            end
          end
        end
        ST_WAIT_VB: begin
          if (gate_d) begin
            state_q <= ST_WR;
            we_q    <= 1'b1;
            addr_q  <= waddr_q;
            wdata_q <= data_q;
            done_q  <= 1'b1;
          end
        end
        ST_WR: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        ST_FILL: begin
          // done_q marks the cycle that wrote the last cell.
          if (done_q) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else if (gate_d) begin
            we_q    <= 1'b1;
            addr_q  <= cnt_q;
            wdata_q <= data_q;
            done_q  <= (cnt_q == LAST);
            cnt_q   <= cnt_q + ADDR_W'(1);
          end
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
